// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin arbiter sharing one multi-cycle multiplier among
// NUM_REQ requesters. Each grant runs one complete four-phase req/ack
// handshake with the multiplier, then one with the granted requester.
// Every output is registered.

module mul_arbiter #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   a_in,
    input  logic [NUM_REQ*WIDTH-1:0]   b_in,
    output logic [NUM_REQ-1:0]         ack,
    output logic [WIDTH-1:0]           out,
    output logic [IDX_W-1:0]           grant_idx,
    output logic                       busy,
    output logic                       mul_req,
    output logic [WIDTH-1:0]           mul_a,
    output logic [WIDTH-1:0]           mul_b,
    input  logic [WIDTH-1:0]           mul_out,
    input  logic                       mul_ack
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_MUL  = 2'd1,
        ST_WAIT_DROP = 2'd2,
        ST_RESPOND   = 2'd3
    } state_t;

    // Pointer reset value: the search starts one above it, so requester 0 wins first.
    localparam logic [IDX_W-1:0]   LAST_RST    = IDX_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT_LSB = {{(NUM_REQ-1){1'b0}}, 1'b1};
    localparam logic [NUM_REQ-1:0] ACK_ZERO    = {NUM_REQ{1'b0}};
    localparam logic [WIDTH-1:0]   DATA_ZERO   = {WIDTH{1'b0}};

    // Registered state and outputs
    state_t               state_r;
    logic [IDX_W-1:0]     last_r;
    logic [IDX_W-1:0]     grant_idx_r;
    logic [NUM_REQ-1:0]   ack_r;
    logic [WIDTH-1:0]     out_r;
    logic                 mul_req_r;
    logic [WIDTH-1:0]     mul_a_r;
    logic [WIDTH-1:0]     mul_b_r;
    logic                 busy_r;

    // Next-state values
    state_t               state_s;
    logic [IDX_W-1:0]     last_s;
    logic [IDX_W-1:0]     grant_idx_s;
    logic [NUM_REQ-1:0]   ack_s;
    logic [WIDTH-1:0]     out_s;
    logic                 mul_req_s;
    logic [WIDTH-1:0]     mul_a_s;
    logic [WIDTH-1:0]     mul_b_s;
    logic                 busy_s;

    // Arbitration helpers
    logic [IDX_W-1:0]     pick_idx_s;
    logic [WIDTH-1:0]     a_pick_s;
    logic [WIDTH-1:0]     b_pick_s;

    // First requester with req set, searching upward from last_v+1 with wrap.
    // Pass one covers indices above last_v, pass two wraps to the bottom.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] req_v,
        input logic [IDX_W-1:0]   last_v
    );
        logic [IDX_W-1:0] sel_v;
        logic             found_v;
        sel_v   = last_v;
        found_v = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found_v && req_v[i] && (i > int'(last_v))) begin
                sel_v   = IDX_W'(i);
                found_v = 1'b1;
            end else begin
                sel_v   = sel_v;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found_v && req_v[i]) begin
                sel_v   = IDX_W'(i);
                found_v = 1'b1;
            end else begin
                sel_v   = sel_v;
            end
        end
        return sel_v;
    endfunction

    // Round-robin winner for the current request vector
    always_comb begin
        pick_idx_s = rr_pick(req, last_r);
    end

    // Operand mux: select the winner's A/B slices
    always_comb begin
        a_pick_s = DATA_ZERO;
        b_pick_s = DATA_ZERO;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (int'(pick_idx_s) == i) begin
                a_pick_s = a_in[i*WIDTH +: WIDTH];
                b_pick_s = b_in[i*WIDTH +: WIDTH];
            end else begin
                a_pick_s = a_pick_s;
                b_pick_s = b_pick_s;
            end
        end
    end

    // FSM next-state and next-output logic; everything holds by default
    always_comb begin
        state_s     = state_r;
        last_s      = last_r;
        grant_idx_s = grant_idx_r;
        ack_s       = ack_r;
        out_s       = out_r;
        mul_req_s   = mul_req_r;
        mul_a_s     = mul_a_r;
        mul_b_s     = mul_b_r;

        case (state_r)
            ST_IDLE: begin
                ack_s = ACK_ZERO;
                // A still-high mul_ack is left over from a transaction this
                // arbiter no longer owns; issuing now would break the handshake.
                if ((|req) && !mul_ack) begin
                    grant_idx_s = pick_idx_s;
                    mul_a_s     = a_pick_s;
                    mul_b_s     = b_pick_s;
                    mul_req_s   = 1'b1;
                    state_s     = ST_WAIT_MUL;
                end else begin
                    mul_req_s   = 1'b0;
                end
            end
            ST_WAIT_MUL: begin
                if (mul_ack) begin
                    out_s     = mul_out;
                    mul_req_s = 1'b0;
                    state_s   = ST_WAIT_DROP;
                end else begin
                    mul_req_s = 1'b1;
                end
            end
            ST_WAIT_DROP: begin
                // Respond only after the multiplier has returned to idle.
                if (!mul_ack) begin
                    ack_s   = ONE_HOT_LSB << grant_idx_r;
                    state_s = ST_RESPOND;
                end else begin
                    ack_s   = ACK_ZERO;
                end
            end
            ST_RESPOND: begin
                // A requester that dropped req early sees a one-cycle ack pulse.
                if (!req[grant_idx_r]) begin
                    ack_s   = ACK_ZERO;
                    last_s  = grant_idx_r;
                    state_s = ST_IDLE;
                end else begin
                    ack_s   = ONE_HOT_LSB << grant_idx_r;
                end
            end
            default: begin
                ack_s     = ACK_ZERO;
                mul_req_s = 1'b0;
                state_s   = ST_IDLE;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            last_r      <= LAST_RST;
            grant_idx_r <= LAST_RST;
            ack_r       <= ACK_ZERO;
            out_r       <= DATA_ZERO;
            mul_req_r   <= 1'b0;
            mul_a_r     <= DATA_ZERO;
            mul_b_r     <= DATA_ZERO;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            last_r      <= last_s;
            grant_idx_r <= grant_idx_s;
            ack_r       <= ack_s;
            out_r       <= out_s;
            mul_req_r   <= mul_req_s;
            mul_a_r     <= mul_a_s;
            mul_b_r     <= mul_b_s;
            busy_r      <= busy_s;
        end
    end

    assign ack       = ack_r;
    assign out       = out_r;
    assign grant_idx = grant_idx_r;
    assign busy      = busy_r;
    assign mul_req   = mul_req_r;
    assign mul_a     = mul_a_r;
    assign mul_b     = mul_b_r;

endmodule

// File: tb/tb_mul_arbiter.sv
// Testbench for mul_arbiter: a behavioural multiplier with adjustable latency
// sits on the mul_* pins; directed scenarios and a randomized run are checked
// against expectations computed from operands the bench chose.

module tb_mul_arbiter;

    localparam int WIDTH   = 32;
    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    logic                       clk;
    logic                       rst;
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*WIDTH-1:0]   a_in;
    logic [NUM_REQ*WIDTH-1:0]   b_in;
    logic [NUM_REQ-1:0]         ack;
    logic [WIDTH-1:0]           out;
    logic [IDX_W-1:0]           grant_idx;
    logic                       busy;
    logic                       mul_req;
    logic [WIDTH-1:0]           mul_a;
    logic [WIDTH-1:0]           mul_b;
    logic [WIDTH-1:0]           mul_out;
    logic                       mul_ack;

    logic                       m_rst;
    int                         m_lat;
    int                         m_phase;
    int                         m_cnt;

    int checks;
    int errors;

    mul_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .ack       (ack),
        .out       (out),
        .grant_idx (grant_idx),
        .busy      (busy),
        .mul_req   (mul_req),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_out   (mul_out),
        .mul_ack   (mul_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural multiplier: four-phase handshake, m_lat extra cycles before ack
    always @(posedge clk) begin
        if (m_rst) begin
            m_phase <= 0;
            m_cnt   <= 0;
            mul_ack <= 1'b0;
            mul_out <= 32'd0;
        end else begin
            case (m_phase)
                0: if (mul_req) begin m_phase <= 1; m_cnt <= m_lat; end
                1: begin
                    if (m_cnt == 0) begin
                        mul_ack <= 1'b1;
                        mul_out <= mul_a * mul_b;
                        m_phase <= 2;
                    end else begin
                        m_cnt <= m_cnt - 1;
                    end
                end
                2: if (!mul_req) begin mul_ack <= 1'b0; m_phase <= 0; end
                default: m_phase <= 0;
            endcase
        end
    end

    // Hard stop in case something never terminates
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1; m_rst = 1'b1; req = 4'b0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; m_rst = 1'b0;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        a_in[i*WIDTH +: WIDTH] = a;
        b_in[i*WIDTH +: WIDTH] = b;
    endtask

    // Wait for any ack bit; lat = cycles from first mul_ack sighting to ack
    task automatic wait_ack(output int lat, output bit tmo);
        int n;
        int t_m;
        n = 0; t_m = -1; tmo = 1'b1; lat = -1;
        while (n < 200) begin
            @(posedge clk); #1;
            n++;
            if (mul_ack && t_m < 0) t_m = n;
            if (ack != 4'b0000) begin
                tmo = 1'b0;
                lat = (t_m < 0) ? -1 : n - t_m;
                break;
            end
        end
    endtask

    // Spec rule: first pending index searching from last+1 with wrap
    function automatic int rr_model(input bit [3:0] pend, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (pend[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic test_reset;
        rst = 1'b1; m_rst = 1'b1; req = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ack !== 4'b0000 || busy !== 1'b0 || mul_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ack=%b busy=%b mul_req=%b, expected 0000 0 0", ack, busy, mul_req);
        end
        checks++;
        if (out !== 32'd0 || mul_a !== 32'd0 || mul_b !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: out=%h mul_a=%h mul_b=%h, expected zeros", out, mul_a, mul_b);
        end
        checks++;
        if (grant_idx !== 2'd3) begin
            errors++;
            $display("FAIL reset_grant: got %0d expected 3", grant_idx);
        end
    endtask

    task automatic test_single;
        int lat; bit tmo;
        do_reset();
        m_lat = 2;
        @(negedge clk);
        set_op(0, 32'd7, 32'd6);
        req = 4'b0001;
        @(posedge clk); #1;
        checks++;
        if (mul_req !== 1'b1 || mul_a !== 32'd7 || mul_b !== 32'd6 || busy !== 1'b1 || grant_idx !== 2'd0) begin
            errors++;
            $display("FAIL single_issue: mul_req=%b a=%0d b=%0d busy=%b grant=%0d, expected 1 7 6 1 0",
                     mul_req, mul_a, mul_b, busy, grant_idx);
        end
        wait_ack(lat, tmo);
        checks++;
        if (tmo || ack !== 4'b0001 || out !== 32'd42 || lat !== 3) begin
            errors++;
            $display("FAIL single_ack: tmo=%b ack=%b out=%0d lat=%0d, expected 0 0001 42 3", tmo, ack, out, lat);
        end
        @(negedge clk); req = 4'b0000;
        @(posedge clk); #1;
        checks++;
        if (ack !== 4'b0000 || out !== 32'd42 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_drop: ack=%b out=%0d busy=%b, expected 0000 42 0", ack, out, busy);
        end
    endtask

    task automatic test_all_four;
        int lat; bit tmo;
        logic [3:0]  exp_ack;
        logic [31:0] exp_out;
        do_reset();
        m_lat = 1;
        @(negedge clk);
        for (int i = 0; i < NUM_REQ; i++) set_op(i, 32'((i + 1) * 3), 32'd2);
        req = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) begin
            exp_ack = 4'b0001 << i;
            exp_out = 32'((i + 1) * 6);
            wait_ack(lat, tmo);
            checks++;
            if (tmo || ack !== exp_ack || out !== exp_out || lat !== 3) begin
                errors++;
                $display("FAIL all_four_grant%0d: tmo=%b ack=%b out=%0d lat=%0d, expected 0 %b %0d 3",
                         i, tmo, ack, out, lat, exp_ack, exp_out);
            end
            if (tmo) return;
            @(negedge clk); req[i] = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (ack !== 4'b0000) begin
                errors++;
                $display("FAIL all_four_drop%0d: ack=%b expected 0000", i, ack);
            end
        end
    endtask

    task automatic test_wrap;
        int lat; bit tmo;
        do_reset();
        m_lat = 0;
        @(negedge clk);
        set_op(2, 32'd5, 32'd5);
        req = 4'b0100;
        wait_ack(lat, tmo);
        checks++;
        if (tmo || ack !== 4'b0100 || out !== 32'd25) begin
            errors++;
            $display("FAIL wrap_setup: tmo=%b ack=%b out=%0d, expected 0 0100 25", tmo, ack, out);
        end
        @(negedge clk);
        set_op(1, 32'd2, 32'd9);
        set_op(3, 32'd4, 32'd4);
        req = 4'b1010;
        wait_ack(lat, tmo);
        checks++;
        if (tmo || ack !== 4'b1000 || out !== 32'd16 || grant_idx !== 2'd3) begin
            errors++;
            $display("FAIL wrap_first: tmo=%b ack=%b out=%0d grant=%0d, expected 0 1000 16 3", tmo, ack, out, grant_idx);
        end
        @(negedge clk); req[3] = 1'b0;
        wait_ack(lat, tmo);
        checks++;
        if (tmo || ack !== 4'b0010 || out !== 32'd18) begin
            errors++;
            $display("FAIL wrap_second: tmo=%b ack=%b out=%0d, expected 0 0010 18", tmo, ack, out);
        end
        @(negedge clk); req = 4'b0000;
        @(posedge clk); #1;
    endtask

    task automatic test_early_drop;
        int lat; bit tmo;
        do_reset();
        m_lat = 4;
        @(negedge clk);
        set_op(2, 32'd11, 32'd13);
        req = 4'b0100;
        @(posedge clk); #1;
        checks++;
        if (mul_req !== 1'b1 || grant_idx !== 2'd2) begin
            errors++;
            $display("FAIL early_issue: mul_req=%b grant=%0d, expected 1 2", mul_req, grant_idx);
        end
        @(negedge clk); req = 4'b0000;
        wait_ack(lat, tmo);
        checks++;
        if (tmo || ack !== 4'b0100 || out !== 32'd143 || lat !== 3) begin
            errors++;
            $display("FAIL early_ack: tmo=%b ack=%b out=%0d lat=%0d, expected 0 0100 143 3", tmo, ack, out, lat);
        end
        @(posedge clk); #1;
        checks++;
        if (ack !== 4'b0000 || busy !== 1'b0 || out !== 32'd143) begin
            errors++;
            $display("FAIL early_pulse: ack=%b busy=%b out=%0d, expected 0000 0 143", ack, busy, out);
        end
    endtask

    task automatic test_rst_mid;
        int lat; bit tmo; int n;
        do_reset();
        m_lat = 3;
        @(negedge clk);
        set_op(1, 32'd9, 32'd9);
        req = 4'b0010;
        n = 0;
        while (n < 50 && mul_ack !== 1'b1) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (mul_ack !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_wait: mul_ack=%b after %0d cycles, expected 1", mul_ack, n);
            return;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ack !== 4'b0000 || out !== 32'd0 || mul_req !== 1'b0 || mul_a !== 32'd0 ||
            mul_b !== 32'd0 || grant_idx !== 2'd3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs: ack=%b out=%h mul_req=%b a=%h b=%h grant=%0d busy=%b, expected reset values",
                     ack, out, mul_req, mul_a, mul_b, grant_idx, busy);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (mul_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_stale: mul_req=%b busy=%b while stale mul_ack, expected 0 0", mul_req, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (mul_req !== 1'b1 || mul_a !== 32'd9 || grant_idx !== 2'd1) begin
            errors++;
            $display("FAIL rst_mid_reissue: mul_req=%b a=%0d grant=%0d, expected 1 9 1", mul_req, mul_a, grant_idx);
        end
        wait_ack(lat, tmo);
        checks++;
        if (tmo || ack !== 4'b0010 || out !== 32'd81 || lat !== 3) begin
            errors++;
            $display("FAIL rst_mid_ack: tmo=%b ack=%b out=%0d lat=%0d, expected 0 0010 81 3", tmo, ack, out, lat);
        end
        @(negedge clk); req = 4'b0000;
        @(posedge clk); #1;
    endtask

    task automatic test_overflow;
        int lat; bit tmo;
        do_reset();
        m_lat = 1;
        @(negedge clk);
        set_op(3, 32'hFFFF_FFFF, 32'd2);
        req = 4'b1000;
        wait_ack(lat, tmo);
        checks++;
        if (tmo || ack !== 4'b1000 || out !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL overflow: tmo=%b ack=%b out=%h, expected 0 1000 fffffffe", tmo, ack, out);
        end
        @(negedge clk); req = 4'b0000;
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        int lat; bit tmo;
        bit [3:0]    pend;
        bit [3:0]    new_m;
        int          last_m;
        int          g;
        logic [31:0] ra [NUM_REQ];
        logic [31:0] rb [NUM_REQ];
        logic [31:0] exp_out;
        logic [3:0]  exp_ack;
        do_reset();
        last_m = 3;
        pend   = 4'b0000;
        @(negedge clk);
        new_m = 4'($urandom_range(1, 15));
        for (int i = 0; i < NUM_REQ; i++) begin
            if (new_m[i]) begin
                ra[i] = $urandom; rb[i] = $urandom;
                set_op(i, ra[i], rb[i]);
                req[i] = 1'b1; pend[i] = 1'b1;
            end
        end
        for (int t = 0; t < 40; t++) begin
            m_lat   = $urandom_range(0, 4);
            g       = rr_model(pend, last_m);
            exp_ack = 4'b0001 << g;
            exp_out = ra[g] * rb[g];
            wait_ack(lat, tmo);
            checks++;
            if (tmo || ack !== exp_ack || out !== exp_out || lat !== 3 || grant_idx !== 2'(g)) begin
                errors++;
                $display("FAIL random_txn%0d: tmo=%b ack=%b out=%h lat=%0d grant=%0d, expected 0 %b %h 3 %0d",
                         t, tmo, ack, out, lat, grant_idx, exp_ack, exp_out, g);
            end
            if (tmo) return;
            @(negedge clk);
            req[g]  = 1'b0;
            pend[g] = 1'b0;
            last_m  = g;
            new_m   = 4'($urandom_range(0, 15)) & ~pend & ~exp_ack;
            if (pend == 4'b0000 && new_m == 4'b0000)
                new_m = 4'b0001 << ((g + 1 + $urandom_range(0, 2)) % NUM_REQ);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (new_m[i]) begin
                    ra[i] = $urandom; rb[i] = $urandom;
                    set_op(i, ra[i], rb[i]);
                    req[i] = 1'b1; pend[i] = 1'b1;
                end
            end
            @(posedge clk); #1;
            checks++;
            if (ack !== 4'b0000) begin
                errors++;
                $display("FAIL random_drop%0d: ack=%b expected 0000", t, ack);
            end
        end
        @(negedge clk); req = 4'b0000;
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; m_rst = 1'b1; req = 4'b0000;
        a_in = 128'd0; b_in = 128'd0;
        m_lat = 2;
        test_reset();
        test_single();
        test_all_four();
        test_wrap();
        test_early_drop();
        test_rst_mid();
        test_overflow();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
